seg7_digit_receiver: RTL
========================

SEG7_DIGIT_RECEIVER -- requirements
Module: seg7_digit_receiver

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000: clk cycles a pattern must hold before capture; legal range 1..65535.
REQ-002 SHALL have parameter MAX_DIGITS, default 3: digits accepted before the number is complete; legal range 1..3.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port seg_in, input, 8 bits: segment pattern, active-high, bit0=a .. bit6=g, bit7=dp; asynchronous to clk.
REQ-006 SHALL have port strobe, input, 1 bit: rising edge announces a new pattern; asynchronous to clk.
REQ-007 SHALL have port clear, input, 1 bit: synchronous restart, active-high.
REQ-008 SHALL have port value, output, 8 bits: accumulated binary number.
REQ-009 SHALL have port digit_count, output, 2 bits: digits accepted so far.
REQ-010 SHALL have port done, output, 1 bit: number complete.
REQ-011 SHALL have port err_invalid, output, 1 bit: sticky flag for an unrecognised pattern.
REQ-012 SHALL have port err_overflow, output, 1 bit: sticky flag for a value above 255.

Function
REQ-013 SHALL pass seg_in and strobe each through a 2-flop synchroniser; strobe edge = sync2 high while its previous-cycle copy was low.
REQ-014 SHALL implement FSM IDLE, SETTLE, CAPTURE, DONE.
REQ-015 IDLE: strobe edge -> SETTLE; latch synchronised pattern; settle counter = 0.
REQ-016 SETTLE: pattern differs from latch -> relatch, counter = 0; counter == STABLE_CYCLES-1 -> CAPTURE; strobe edges ignored.
REQ-017 CAPTURE lasts exactly 1 cycle; SHALL decode bits 6:0: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9; every other pattern, blank 0x00 included, is invalid.
REQ-018 Valid digit d: value <= value*10+d, computed at 12 bits; result >255 -> value <= 255 and err_overflow <= 1; digit_count increments.
REQ-019 Invalid pattern: err_invalid <= 1; value and digit_count unchanged; next state IDLE.
REQ-020 After a valid capture: next state DONE if digit_count reaches MAX_DIGITS, else IDLE.
REQ-021 DONE: done = 1; strobe edges ignored; exit only via clear or reset.
REQ-022 Latency: stable input gives the value update on clk edge STABLE_CYCLES+4, counting the edge that first samples strobe high as edge 1.
REQ-023 clear = 1: all outputs zero and FSM to IDLE on that edge, in any state; a simultaneous strobe edge is dropped.
REQ-024 Once saturated at 255, further digits keep value at 255 and digit_count still increments.

Reset
REQ-025 rst_n low SHALL immediately force: FSM IDLE; value, digit_count, done, err_invalid, err_overflow, settle counter and synchronisers to 0.
REQ-026 Reset mid-SETTLE or mid-CAPTURE SHALL abandon the digit with no partial update.
REQ-027 Operation SHALL start on the first clk edge after rst_n is released.

Configuration
REQ-028 Macro SEG7_RX_DP_EN defined: a valid digit captured with latched bit7 = 1 SHALL be accumulated, then force DONE regardless of digit_count.
REQ-029 Macro SEG7_RX_DP_EN undefined: bit7 SHALL be ignored everywhere, including the SETTLE change comparison.

Structure
REQ-030 Package seg7_pkg SHALL hold SEG_0..SEG_9 pattern constants (shared with the display-encoder side), the FSM state typedef, and the value width 8.
REQ-031 Sub-module seg7_pattern_decoder SHALL be purely combinational: 7-bit pattern -> 4-bit digit plus valid bit.

Verification (bench STABLE_CYCLES=4, MAX_DIGITS=3)
REQ-032 Strobe patterns 0x06, 0x5B, 0x4F (digits 1, 2, 3) -> value=123, digit_count=3, done=1, both error flags 0.
REQ-033 Strobe 0x7F, 0x7F, 0x7F (digits 8, 8, 8) -> value=255, err_overflow=1, done=1.
REQ-034 Strobe 0x49 -> err_invalid=1, value=0, digit_count=0, FSM back in IDLE; then 0x66 -> value=4.
REQ-035 Pattern changes 0x06 -> 0x6D two cycles after the strobe edge -> digit 5 captured, at edge 6+4 from the first strobe sample.
REQ-036 rst_n pulsed low during SETTLE, and separately clear raised in DONE -> all outputs 0 and a new number is accepted.
REQ-037 With SEG7_RX_DP_EN: strobe 0x06 then 0xDB (digit 2 with dp) -> value=12, done=1, digit_count=2.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment digit receiver: segment patterns
// (bit0=a .. bit6=g, active-high), FSM state type and value width.
package seg7_pkg;

  localparam int VALUE_W = 8;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational 7-segment pattern to BCD digit decoder; any pattern that is
// not one of the ten digit shapes (blank included) reports valid = 0.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_digit_receiver.sv
// Receives strobed 7-segment patterns, debounces them and accumulates a
// decimal number. Define SEG7_RX_DP_EN to let the decimal point end a number.
module seg7_digit_receiver
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000,
  parameter int MAX_DIGITS    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         seg_in,
  input  logic               strobe,
  input  logic               clear,
  output logic [VALUE_W-1:0] value,
  output logic [1:0]         digit_count,
  output logic               done,
  output logic               err_invalid,
  output logic               err_overflow
);

  localparam logic [15:0] SETTLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [1:0]  MAX_CNT     = 2'(MAX_DIGITS);

`ifdef SEG7_RX_DP_EN
  localparam logic [7:0] CMP_MASK = 8'hFF;
`else
  localparam logic [7:0] CMP_MASK = 8'h7F;
`endif

  logic [7:0]         seg_sync1_reg, seg_sync2_reg;
  logic               strobe_sync1_reg, strobe_sync2_reg, strobe_prev_reg;
  state_t             state_reg;
  logic [7:0]         pattern_reg;
  logic [15:0]        settle_cnt_reg;
  logic [VALUE_W-1:0] value_reg;
  logic [1:0]         count_reg;
  logic               done_reg, err_inv_reg, err_ovf_reg;

  logic        strobe_edge;
  logic [3:0]  digit;
  logic        digit_valid;
  logic [11:0] acc_next;
  logic [1:0]  count_inc;
  logic        dp_stop;
  logic        last_digit;

  seg7_pattern_decoder u_decoder (
    .pattern (pattern_reg[6:0]),
    .digit   (digit),
    .valid   (digit_valid)
  );

  assign strobe_edge = strobe_sync2_reg & ~strobe_prev_reg;
  assign acc_next    = 12'(value_reg) * 12'd10 + 12'(digit);
  assign count_inc   = count_reg + 2'd1;

`ifdef SEG7_RX_DP_EN
  assign dp_stop = pattern_reg[7];
`else
  assign dp_stop = 1'b0;
`endif

  assign last_digit = (count_inc == MAX_CNT) || dp_stop;

  // Both inputs come from another clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sync1_reg    <= 8'd0;
      seg_sync2_reg    <= 8'd0;
      strobe_sync1_reg <= 1'b0;
      strobe_sync2_reg <= 1'b0;
      strobe_prev_reg  <= 1'b0;
    end else begin
      seg_sync1_reg    <= seg_in;
      seg_sync2_reg    <= seg_sync1_reg;
      strobe_sync1_reg <= strobe;
      strobe_sync2_reg <= strobe_sync1_reg;
      strobe_prev_reg  <= strobe_sync2_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      pattern_reg    <= 8'd0;
      settle_cnt_reg <= 16'd0;
      value_reg      <= '0;
      count_reg      <= 2'd0;
      done_reg       <= 1'b0;
      err_inv_reg    <= 1'b0;
      err_ovf_reg    <= 1'b0;
    end else if (clear) begin
      state_reg      <= ST_IDLE;
      pattern_reg    <= 8'd0;
      settle_cnt_reg <= 16'd0;
      value_reg      <= '0;
      count_reg      <= 2'd0;
      done_reg       <= 1'b0;
      err_inv_reg    <= 1'b0;
      err_ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (strobe_edge) begin
            state_reg      <= ST_SETTLE;
            pattern_reg    <= seg_sync2_reg;
            settle_cnt_reg <= 16'd0;
          end
        end
        ST_SETTLE: begin
          // A changed pattern restarts the stability window.
          if ((seg_sync2_reg & CMP_MASK) != (pattern_reg & CMP_MASK)) begin
            pattern_reg    <= seg_sync2_reg;
            settle_cnt_reg <= 16'd0;
          end else if (settle_cnt_reg == SETTLE_LAST) begin
            state_reg <= ST_CAPTURE;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 16'd1;
          end
        end
        ST_CAPTURE: begin
          if (digit_valid) begin
            if (acc_next > 12'd255) begin
              value_reg   <= 8'hFF;
              err_ovf_reg <= 1'b1;
            end else begin
              value_reg <= acc_next[7:0];
            end
            count_reg <= count_inc;
            if (last_digit) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            err_inv_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end
        end
        ST_DONE: begin
          done_reg <= 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign value        = value_reg;
  assign digit_count  = count_reg;
  assign done         = done_reg;
  assign err_invalid  = err_inv_reg;
  assign err_overflow = err_ovf_reg;

endmodule
